// File: rtl/present_pkg.sv
// Shared PRESENT constants, FSM encoding and S-box helpers.
// Build option: define PRESENT_KEY128_EN for the 128-bit key schedule.
package present_pkg;

`ifdef PRESENT_KEY128_EN
  localparam int KEY_W = 128;
`else
  localparam int KEY_W = 80;
`endif

  localparam int STATE_W = 64;
  localparam int ROUNDS  = 31;
  localparam int ROUND_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } fsm_e;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [STATE_W-1:0] sbox_layer(input logic [STATE_W-1:0] x);
    logic [STATE_W-1:0] y;
    y = '0;
    for (int i = 0; i < STATE_W / 4; i++) begin
      y[4*i +: 4] = sbox4(x[4*i +: 4]);
    end
    return y;
  endfunction

endpackage

// File: rtl/PLayer.sv
// PRESENT bit permutation: bit i moves to i*size/4 mod (size-1); the top bit stays put.
module PLayer #(
  parameter int size = 64
) (
  input  logic [size-1:0] original,
  output logic [size-1:0] permuted
);

  for (genvar i = 0; i < size; i++) begin : g_bit
    localparam int DST = (i == size - 1) ? i : (i * (size / 4)) % (size - 1);
    assign permuted[DST] = original[i];
  end

endmodule

// File: rtl/present_key_update.sv
// Combinational PRESENT key-schedule step (80-bit, or 128-bit with PRESENT_KEY128_EN).
module present_key_update
  import present_pkg::*;
(
  input  logic [KEY_W-1:0]   key_i,
  input  logic [ROUND_W-1:0] round_i,
  output logic [KEY_W-1:0]   key_o
);

  logic [KEY_W-1:0] rot;

  always_comb begin
    rot   = {key_i[KEY_W-62:0], key_i[KEY_W-1:KEY_W-61]};
    key_o = rot;
`ifdef PRESENT_KEY128_EN
    key_o[127:124] = sbox4(rot[127:124]);
    key_o[123:120] = sbox4(rot[123:120]);
    key_o[66:62]   = rot[66:62] ^ round_i;
`else
    key_o[79:76]   = sbox4(rot[79:76]);
    key_o[19:15]   = rot[19:15] ^ round_i;
`endif
  end

endmodule

// File: rtl/present_round_ctrl.sv
// Iterative PRESENT encryption: one round per clock, then a final key whitening.
// Key width follows PRESENT_KEY128_EN (see present_pkg).
module present_round_ctrl #(
  parameter int ROUNDS = present_pkg::ROUNDS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [63:0]               plaintext,
  input  logic [present_pkg::KEY_W-1:0] key,
  output logic                      busy,
  output logic                      done,
  output logic [63:0]               ciphertext,
  output logic [1:0]                dbg_state_o
);
  import present_pkg::*;

  fsm_e                 state_q, state_d;
  logic [STATE_W-1:0]   data_q, data_d;
  logic [KEY_W-1:0]     key_q, key_d, key_next;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [STATE_W-1:0]   ct_q, ct_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic [STATE_W-1:0]   sbox_out, perm_out;

  assign sbox_out = sbox_layer(data_q ^ key_q[KEY_W-1 -: STATE_W]);

  PLayer #(.size(STATE_W)) u_player (
    .original (sbox_out),
    .permuted (perm_out)
  );

  present_key_update u_key_update (
    .key_i   (key_q),
    .round_i (round_q),
    .key_o   (key_next)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    key_d   = key_q;
    round_d = round_q;
    ct_d    = ct_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = plaintext;
          key_d   = key;
          round_d = ROUND_W'(1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        data_d = perm_out;
        key_d  = key_next;
        // Counter holds at the last round so it never wraps before FINAL.
        if (round_q == ROUND_W'(ROUNDS)) state_d = FINAL;
        else                             round_d = round_q + ROUND_W'(1);
      end
      FINAL: begin
        ct_d    = data_q ^ key_q[KEY_W-1 -: STATE_W];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      key_q   <= '0;
      round_q <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      key_q   <= key_d;
      round_q <= round_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ciphertext  = ct_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_present_round_ctrl.sv
// Self-checking bench for present_round_ctrl against an algorithmic PRESENT model.
module tb_present_round_ctrl;
  import present_pkg::*;

`ifdef PRESENT_KEY128_EN
  localparam int KW = 128;
`else
  localparam int KW = 80;
`endif

  localparam logic [3:0] SB_TAB [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  logic          clk = 1'b0;
  logic          reset, start;
  logic [63:0]   plaintext;
  logic [KW-1:0] key;
  logic          busy, done;
  logic [63:0]   ciphertext;
  logic [1:0]    dbg_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          done_cnt = 0;
  int          d0;
  logic [63:0] exp_q[$];
  int          lat_q[$];
  logic [63:0] last_ct;
  logic [63:0] mon_e;
  int          mon_s;

  present_round_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .plaintext   (plaintext),
    .key         (key),
    .busy        (busy),
    .done        (done),
    .ciphertext  (ciphertext),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [63:0] ref_sbox(input logic [63:0] s);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[4*i +: 4] = SB_TAB[s[4*i +: 4]];
    return o;
  endfunction

  function automatic logic [63:0] ref_perm(input logic [63:0] s);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[(i == 63) ? 63 : (i * 16) % 63] = s[i];
    return o;
  endfunction

  function automatic logic [KW-1:0] ref_key_next(input logic [KW-1:0] k, input int r);
    logic [KW-1:0] t;
    logic [4:0]    rc;
    rc = 5'(r);
    t  = (k << 61) | (k >> (KW - 61));
    t[KW-1 -: 4] = SB_TAB[t[KW-1 -: 4]];
`ifdef PRESENT_KEY128_EN
    t[KW-5 -: 4] = SB_TAB[t[KW-5 -: 4]];
    t[66:62] = t[66:62] ^ rc;
`else
    t[19:15] = t[19:15] ^ rc;
`endif
    return t;
  endfunction

  function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [KW-1:0] k);
    logic [63:0]   s;
    logic [KW-1:0] kk;
    s  = pt;
    kk = k;
    for (int r = 1; r <= 31; r++) begin
      s  = ref_perm(ref_sbox(s ^ kk[KW-1 -: 64]));
      kk = ref_key_next(kk, r);
    end
    return s ^ kk[KW-1 -: 64];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [KW-1:0] rnd_key();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[KW-1:0];
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'(done), 64'h0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_s = lat_q.pop_front();
        check("ciphertext", ciphertext, mon_e);
        check("latency", 64'(cyc - mon_s), 64'd32);
        check("busy_at_done", 64'(busy), 64'h0);
        last_ct = mon_e;
      end
    end
  end

  // driver tasks
  task automatic launch(input logic [63:0] pt, input logic [KW-1:0] k);
    start     = 1'b1;
    plaintext = pt;
    key       = k;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back(ref_encrypt(pt, k));
    lat_q.push_back(cyc);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) check("busy_after_start", 64'(busy), 64'h1);
      if (i == 4) check("ct_held", ciphertext, last_ct);
      if (done) break;
    end
    check("done_seen", 64'(done), 64'h1);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    plaintext = '0;
    key       = '0;
    last_ct   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_ct", ciphertext, 64'h0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));

    // reset and start together: reset wins
    start     = 1'b1;
    plaintext = rnd64();
    key       = rnd_key();
    @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_start_busy", 64'(busy), 64'h0);
    check("rst_start_state", 64'(dbg_state), 64'(IDLE));
    repeat (3) @(negedge clk);

    // known-answer vectors
`ifdef PRESENT_KEY128_EN
    launch(64'h0, '0);
    wait_done();
    check("kat128_zero", ciphertext, 64'h96DB702A2E6900AF);
`else
    launch(64'h0, '0);
    wait_done();
    check("kat_zero", ciphertext, 64'h5579C1387B228445);
    launch(64'h0, '1);
    wait_done();
    check("kat_key_ones", ciphertext, 64'hE72C46C0F5945049);
    launch(64'hFFFFFFFFFFFFFFFF, '0);
    wait_done();
    check("kat_pt_ones_b2b", ciphertext, 64'hA112FFC72F68417B);
`endif

    // start mid-operation is ignored
    launch(rnd64(), rnd_key());
    repeat (10) @(negedge clk);
    start     = 1'b1;
    plaintext = rnd64();
    key       = rnd_key();
    @(posedge clk);
    #1;
    start = 1'b0;
    d0 = done_cnt;
    wait_done();
    repeat (5) @(negedge clk);
    check("single_done", 64'(done_cnt - d0), 64'd1);

    // reset mid-operation aborts
    launch(rnd64(), rnd_key());
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    lat_q.delete();
    last_ct = '0;
    d0 = done_cnt;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_done", 64'(done), 64'h0);
    check("abort_ct", ciphertext, 64'h0);
    check("abort_state", 64'(dbg_state), 64'(IDLE));
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);

    // random vectors, back-to-back or with short gaps
    for (int n = 0; n < 10; n++) begin
      launch(rnd64(), rnd_key());
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/present_round_ctrl.md
# present_round_ctrl

Iterative PRESENT block-cipher encryption controller. It sequences one round per clock through the existing `PLayer` permutation, together with an S-box layer and a round-key XOR, over 31 rounds plus a final key whitening. It holds the evolving key register and the round counter. It sits between the host interface and the combinational `PLayer`/S-box datapath, and is the block the crypto top level instantiates.

## Interface
Parameters:
- `ROUNDS`, default 31: number of full rounds; fixed by the PRESENT standard and not meant to be overridden.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request encryption. Sampled only in IDLE.
- `plaintext`, input, 64: block to encrypt. Captured on the edge that accepts `start`.
- `key`, input, 80 (128 with `PRESENT_KEY128_EN`): cipher key. Captured with `plaintext`.
- `busy`, output, 1: high while in ROUND or FINAL.
- `done`, output, 1: single-cycle pulse when `ciphertext` is updated.
- `ciphertext`, output, 64: result. Held stable until the next completion.

## Operation
FSM states and transitions:
- IDLE: on `start=1`, load `state_reg<=plaintext`, `key_reg<=key`, `round<=1`; go to ROUND.
- ROUND, each cycle:
  - `state_reg <= PLayer(SBoxLayer(state_reg ^ key_reg[KEY_W-1 -: 64]))`.
  - `key_reg <= key_update(key_reg, round)`.
  - `round <= round+1`.
  - When `round==ROUNDS`, go to FINAL.
- FINAL:
  - `ciphertext <= state_reg ^ key_reg[KEY_W-1 -: 64]`.
  - `done<=1` for this one transition only.
  - Go to IDLE.

Key update (80-bit), applied in order:
- Rotate left 61.
- S-box on bits [79:76].
- `[19:15] ^= round[4:0]`.

`round` is 5 bits, counts 1..31, and never wraps inside an operation.

SBoxLayer: 16 parallel 4-bit PRESENT S-boxes (C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2).

Boundary behaviour:
- `start` during ROUND or FINAL is ignored. There is no queueing, and `plaintext`/`key` changes mid-operation have no effect.
- `start` high in the cycle `done` is high: FSM is already in IDLE, so the request is accepted. This gives back-to-back operation with no bubble.
- `reset` mid-operation aborts immediately: FSM to IDLE, no `done` pulse.
- `reset` and `start` together: `reset` wins.
- `ciphertext` is not cleared by `start`. It keeps the previous result until FINAL overwrites it.

## Timing
- Reset values: `busy=0`, `done=0`, `ciphertext=64'h0`, FSM=IDLE, `round=0`, `state_reg=0`, `key_reg=0`.
- Edge E0 samples `start`. The FSM is in ROUND after E0, and `busy=1` from E0.
- Rounds are applied on edges E1..E31. E32 is the FINAL edge.
- `done=1` and the new `ciphertext` are visible in the cycle after E32. `busy=0` in that same cycle.
- Start-to-done latency: 32 clocks. Throughput: one block per 32 clocks.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `PRESENT_KEY128_EN` defined: `key` and `key_reg` are 128 bits. The key update becomes, in order:
  - Rotate left 61.
  - S-box on [127:124] and [123:120].
  - `[66:62] ^= round[4:0]`.
  
  Round keys are `key_reg[127:64]`.
- Not defined: 80-bit key path only, as described above. FSM, latency and handshake are identical in both builds.

## Structure
- Package `present_pkg`:
  - `STATE_W=64` and `KEY_W` (80 or 128, under the macro).
  - `ROUNDS=31`.
  - FSM enum `{IDLE, ROUND, FINAL}`.
  - S-box constant array and `sbox4`/`sbox_layer` functions.
- Reuse the existing `PLayer` (`.permuted`, `.original`) with `size`=64.
- One natural sub-module: `present_key_update`, a combinational next-key function of (`key_reg`, `round`). It holds the macro-dependent width logic.

## Test plan
- 80-bit key, pt=64'h0, key=80'h0 → `done` exactly 32 clocks after the `start` edge, `ciphertext`=64'h5579C1387B228445.
- 80-bit key=80'hFFFF_FFFFFFFFFFFFFFFF, pt=64'h0 → 64'hE72C46C0F5945049. Then pt=64'hFFFFFFFFFFFFFFFF, key=0 → 64'hA112FFC72F68417B, started back-to-back in the `done` cycle.
- `start` pulsed at round 10 with different pt/key → ignored. Result still matches the first vector, and only one `done` pulse occurs.
- `reset` asserted at round 15 → next cycle `busy=0`, no `done`, `ciphertext`=0. A new `start` then completes correctly.
- Reset value check after power-up, and `reset`+`start` in the same cycle → stays IDLE with `busy=0`.
- With `PRESENT_KEY128_EN`: pt=0, key=128'h0 → 64'h96DB702A2E6900AF, same 32-clock latency.
